free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 en_flag_i  input  1  pipeline enable; 0 freezes all state.
REQ-004 alloc_req_1  input  1  rename requests one physical register for slot 1.
REQ-005 alloc_req_2  input  1  rename requests one physical register for slot 2.
REQ-006 rt_flag_1  input  1  retire releases old physical register fp_i_1.
REQ-007 fp_i_1  input  6  index of physical register released by retire slot 1.
REQ-008 rt_flag_2  input  1  retire releases old physical register fp_i_2.
REQ-009 fp_i_2  input  6  index of physical register released by retire slot 2.
REQ-010 alloc_grant  output  1  all requested registers granted this cycle (combinational).
REQ-011 alloc_p_1  output  6  register granted to slot 1 (combinational).
REQ-012 alloc_p_2  output  6  register granted to slot 2 (combinational).
REQ-013 free_count  output  7  registered number of free entries, 0..63.
REQ-014 fl_empty  output  1  free_count == 0.
REQ-015 err_o  output  1  sticky: illegal release detected.
REQ-016 en_flag_o  output  1  en_flag_i delayed one cycle.

Function
REQ-017 Storage: 64-entry circular FIFO of 6-bit indices; 6-bit head and tail pointers wrap 63->0; 64-bit is_free bitmap.
REQ-018 need = alloc_req_1 + alloc_req_2 (0..2); alloc_grant = en_flag_i & (need != 0) & (need <= free_count); all-or-nothing, no partial grant.
REQ-019 Slot 1 receives fifo[head] when alloc_req_1; slot 2 receives fifo[head+1] if alloc_req_1, else fifo[head]; indices wrap mod 64.
REQ-020 alloc_p_1/alloc_p_2 are don't-care when not granted; a bench checks them only when alloc_grant=1.
REQ-021 On the grant edge, head advances by need and is_free clears for each granted index.
REQ-022 Release, when en_flag_i=1: a valid release writes fp_i at tail, tail advances, is_free sets; if both flags are valid, fp_i_1 goes to tail and fp_i_2 to tail+1.
REQ-023 Release of index 0 is silently dropped: x0 mapping is permanent.
REQ-024 Release of an index already free, or fp_i_1 == fp_i_2 with both flags set, is dropped and sets err_o.
REQ-025 Grant decision uses pre-edge free_count only; a register released in cycle N is allocatable from cycle N+1 (no same-cycle bypass).
REQ-026 Simultaneous allocation and release in one cycle: free_count(next) = free_count - granted + accepted releases.
REQ-027 free_count never exceeds 63 by construction; reaching 64 sets err_o.
REQ-028 en_flag_i=0: no grant, releases ignored, pointers/count/bitmap hold; en_flag_o follows with 1-cycle delay.

Reset
REQ-029 On reset: fifo[k] = 32+k for k = 0..31, head = 0, tail = 32, free_count = 32.
REQ-030 On reset: is_free set for p32..p63 only, err_o = 0, en_flag_o = 0.
REQ-031 Reset asserted mid-operation discards in-flight requests/releases that cycle; the reset state is exact on the next cycle.

Structure
REQ-032 Package p holds NUM_PREGS = 64, PREG_W = 6, NUM_AREGS = 32 and the preg_idx_t typedef, shared with the rename and complete stages.
REQ-033 Single module, no sub-module; FIFO and bitmap are inline.
REQ-034 Only alloc_grant, alloc_p_1 and alloc_p_2 are combinational; all other outputs are registered.

Verification
REQ-035 Reset, then alloc_req_1=alloc_req_2=1 -> grant=1, p_1=32, p_2=33; next cycle free_count=30.
REQ-036 16 dual allocations drain the list -> free_count=0, fl_empty=1; a further single request -> grant=0, state unchanged.
REQ-037 From empty, rt_flag_1=1 fp_i_1=40 with alloc_req_1=1 same cycle -> grant=0; next cycle alloc_req_1 -> p_1=40.
REQ-038 Release fp_i_1=5, fp_i_2=7 together -> free_count+2; later allocations return 5 then 7, in that order, after older entries.
REQ-039 Release fp_i_1=0 -> dropped, err_o=0; release an already-free register 45 -> dropped, err_o=1 and stays 1 until reset.
REQ-040 Wrap-around: 100 random alloc/release cycles past index 63 -> no duplicate outstanding grant, and free_count matches the model each cycle.

Source files
------------

// File: rtl/free_list_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | free_list_pkg                                                        |
// | Physical-register sizing shared by rename, complete and free list.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package free_list_pkg;
    localparam int NUM_PREGS = 64;
    localparam int PREG_W    = 6;
    localparam int NUM_AREGS = 32;
    localparam int CNT_W     = 7;

    typedef logic [PREG_W-1:0] preg_idx_t;
endpackage
`default_nettype wire

// File: rtl/free_list.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | free_list                                                            |
// | Two-wide physical register free list: circular FIFO plus is_free map.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module free_list
    import free_list_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en_flag_i,
    input  logic              alloc_req_1,
    input  logic              alloc_req_2,
    input  logic              rt_flag_1,
    input  logic [PREG_W-1:0] fp_i_1,
    input  logic              rt_flag_2,
    input  logic [PREG_W-1:0] fp_i_2,
    output logic              alloc_grant,
    output logic [PREG_W-1:0] alloc_p_1,
    output logic [PREG_W-1:0] alloc_p_2,
    output logic [CNT_W-1:0]  free_count,
    output logic              fl_empty,
    output logic              err_o,
    output logic              en_flag_o
);

    preg_idx_t              r_fifo [NUM_PREGS];
    preg_idx_t              r_head;
    preg_idx_t              r_tail;
    logic [NUM_PREGS-1:0]   r_is_free;
    logic [CNT_W-1:0]       r_free_count;
    logic                   r_fl_empty;
    logic                   r_err;
    logic                   r_en_d;

    logic [1:0]             w_need;
    logic                   w_grant;
    preg_idx_t              w_head_p1;
    logic                   w_nz_1;
    logic                   w_nz_2;
    logic                   w_dup;
    logic                   w_rel_1;
    logic                   w_rel_2;
    logic                   w_bad;
    logic [1:0]             w_granted;
    logic [1:0]             w_accepted;
    logic [CNT_W-1:0]       w_count_next;
    preg_idx_t              w_tail_2;
    logic [NUM_PREGS-1:0]   w_is_free_next;

    assign w_need    = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    assign w_grant   = en_flag_i & (w_need != 2'd0) & ({5'b0, w_need} <= r_free_count);
    assign w_head_p1 = r_head + 6'd1;

    assign alloc_grant = w_grant;
    assign alloc_p_1   = r_fifo[r_head];
    assign alloc_p_2   = alloc_req_1 ? r_fifo[w_head_p1] : r_fifo[r_head];

    // Index 0 is never released. On a same-index double release slot 1 is
    // kept (if otherwise legal) and slot 2 is the dropped, flagged one.
    assign w_nz_1  = rt_flag_1 & (fp_i_1 != '0);
    assign w_nz_2  = rt_flag_2 & (fp_i_2 != '0);
    assign w_dup   = rt_flag_1 & rt_flag_2 & (fp_i_1 == fp_i_2);
    assign w_rel_1 = w_nz_1 & ~r_is_free[fp_i_1];
    assign w_rel_2 = w_nz_2 & ~r_is_free[fp_i_2] & ~w_dup;
    assign w_bad   = (w_nz_1 & r_is_free[fp_i_1]) |
                     (w_nz_2 & (r_is_free[fp_i_2] | w_dup));

    assign w_granted    = w_grant ? w_need : 2'd0;
    assign w_accepted   = {1'b0, w_rel_1} + {1'b0, w_rel_2};
    assign w_count_next = r_free_count - {5'b0, w_granted} + {5'b0, w_accepted};
    assign w_tail_2     = r_tail + {5'b0, w_rel_1};

    always_comb begin
        w_is_free_next = r_is_free;
        if (w_grant && alloc_req_1) w_is_free_next[alloc_p_1] = 1'b0;
        if (w_grant && alloc_req_2) w_is_free_next[alloc_p_2] = 1'b0;
        if (w_rel_1)                w_is_free_next[fp_i_1]    = 1'b1;
        if (w_rel_2)                w_is_free_next[fp_i_2]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_PREGS; k++) begin
                r_fifo[k] <= (k < NUM_AREGS) ? preg_idx_t'(NUM_AREGS + k) : '0;
            end
            r_head       <= '0;
            r_tail       <= preg_idx_t'(NUM_AREGS);
            r_is_free    <= {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};
            r_free_count <= CNT_W'(NUM_AREGS);
            r_fl_empty   <= 1'b0;
            r_err        <= 1'b0;
            r_en_d       <= 1'b0;
        end else begin
            r_en_d <= en_flag_i;
            if (en_flag_i) begin
                r_head <= r_head + {4'b0, w_granted};
                if (w_rel_1) r_fifo[r_tail]   <= fp_i_1;
                if (w_rel_2) r_fifo[w_tail_2] <= fp_i_2;
                r_tail       <= r_tail + {4'b0, w_accepted};
                r_is_free    <= w_is_free_next;
                r_free_count <= w_count_next;
                r_fl_empty   <= (w_count_next == '0);
                if (w_bad || (w_count_next == CNT_W'(NUM_PREGS))) r_err <= 1'b1;
            end
        end
    end

    assign free_count = r_free_count;
    assign fl_empty   = r_fl_empty;
    assign err_o      = r_err;
    assign en_flag_o  = r_en_d;

endmodule
`default_nettype wire
